// File: rtl/cnn_tiled_processor_pkg.sv
// Shared types, width derivations and the post-processing arithmetic for the
// tiled CNN output-channel engine.
package cnn_proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int calc_acc_bw(input int i_bw, input int w_bw, input int n);
    return i_bw + w_bw + clog2(n) + 1;
  endfunction

  function automatic int calc_ab_bw(input int acc_bw, input int b_bw);
    return ((acc_bw > b_bw) ? acc_bw : b_bw) + 1;
  endfunction

  // Round-half-up arithmetic shift, optional ReLU, then clamp to an o_bw signed range.
  function automatic logic signed [63:0] round_shift_relu_sat(
      input logic signed [63:0] b, input logic [4:0] shift, input logic relu, input int o_bw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (o_bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (o_bw - 1));
    if (shift != 5'd0) r = (b + (64'sd1 <<< (shift - 5'd1))) >>> shift;
    else               r = b;
    if (relu && (r < 64'sd0)) r = 64'sd0;
    else                      r = r;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    else             r = r;
    return r;
  endfunction

endpackage

// File: rtl/cnn_tiled_processor_if.sv
// Window input stream and result output stream of the tiled CNN engine.
interface cnn_tiled_processor_if #(
  parameter int N      = 9,
  parameter int I_F_BW = 8,
  parameter int CO     = 4,
  parameter int O_F_BW = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N*I_F_BW-1:0]    feature_map;
  logic                   out_valid;
  logic                   out_ready;
  logic [CO*O_F_BW-1:0]   out_feature;

  modport master (output in_valid, feature_map, out_ready,
                  input  in_ready, out_valid, out_feature);
  modport slave  (input  in_valid, feature_map, out_ready,
                  output in_ready, out_valid, out_feature);
endinterface

// File: rtl/cnn_tiled_processor_lane_mac.sv
// One MAC lane: exact N-term signed dot product, registered to ACC_BW.
module cnn_lane_mac
  import cnn_proc_pkg::*;
#(
  parameter int N      = 9,
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int ACC_BW = 21
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     soft_rst,
  input  logic [N*I_F_BW-1:0]      window,
  input  logic [N*W_BW-1:0]        weights,
  output logic signed [ACC_BW-1:0] acc
);
  logic signed [ACC_BW-1:0] sum_s;
  logic signed [ACC_BW-1:0] acc_r;

  // Combinational dot product of the window with this lane's channel weights.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < N; i++) begin
      sum_s = sum_s + ACC_BW'($signed(window[i*I_F_BW +: I_F_BW]))
                    * ACC_BW'($signed(weights[i*W_BW +: W_BW]));
    end
  end

  // Stage-1 accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        acc_r <= '0;
    else if (soft_rst) acc_r <= '0;
    else               acc_r <= sum_s;
  end

  assign acc = acc_r;
endmodule

// File: rtl/cnn_tiled_processor.sv
// Tiled CNN output-channel engine: P MAC lanes swept over CO/P passes, then
// bias, rounding shift, ReLU and saturation into a held output buffer.
module cnn_tiled_processor
  import cnn_proc_pkg::*;
#(
  parameter int CI     = 1,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int CO     = 4,
  parameter int P      = 2,
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int B_BW   = 16,
  parameter int O_F_BW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   soft_rst,
  input  logic                   cfg_relu,
  input  logic [4:0]             cfg_shift,
  input  logic [CO*CI*KX*KY*W_BW-1:0] weights,
  input  logic [CO*B_BW-1:0]     biases,
  cnn_tiled_processor_if.slave   bus
);
  localparam int N      = CI * KX * KY;
  localparam int G      = CO / P;
  localparam int ACC_BW = calc_acc_bw(I_F_BW, W_BW, N);
  localparam int AB_BW  = calc_ab_bw(ACC_BW, B_BW);
  localparam int GW     = clog2(G + 1);

  state_e                state_r;
  logic [GW-1:0]         g_r;
  logic [GW-1:0]         s1_g_r;
  logic                  s1_valid_r;
  logic [N*I_F_BW-1:0]   feat_r;
  logic                  relu_r;
  logic [4:0]            shift_r;
  logic                  out_valid_r;
  logic [CO*O_F_BW-1:0]  out_feature_r;

  logic [N*W_BW-1:0]        lane_w_s   [P];
  logic signed [ACC_BW-1:0] lane_acc_s [P];
  logic signed [AB_BW-1:0]  b_s        [P];
  logic [O_F_BW-1:0]        r_s        [P];

  // Select each lane's channel weights for the pass being issued; g_r == G means drained.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      if (g_r < GW'(G)) lane_w_s[p] = weights[(int'(g_r) * P + p) * N * W_BW +: N * W_BW];
      else              lane_w_s[p] = '0;
    end
  end

  for (genvar gp = 0; gp < P; gp++) begin : g_lane
    cnn_lane_mac #(.N(N), .I_F_BW(I_F_BW), .W_BW(W_BW), .ACC_BW(ACC_BW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .soft_rst (soft_rst),
      .window   (feat_r),
      .weights  (lane_w_s[gp]),
      .acc      (lane_acc_s[gp])
    );
  end

  // Stage 2: add bias of the channel held in stage 1 and post-process.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      if (s1_g_r < GW'(G)) begin
        b_s[p] = AB_BW'(lane_acc_s[p])
               + AB_BW'($signed(biases[(int'(s1_g_r) * P + p) * B_BW +: B_BW]));
      end else begin
        b_s[p] = AB_BW'(lane_acc_s[p]);
      end
      r_s[p] = O_F_BW'(round_shift_relu_sat(64'(b_s[p]), shift_r, relu_r, O_F_BW));
    end
  end

  // Control FSM, pass counter, stage-1 valid and output buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      g_r           <= '0;
      s1_g_r        <= '0;
      s1_valid_r    <= 1'b0;
      feat_r        <= '0;
      relu_r        <= 1'b0;
      shift_r       <= 5'd0;
      out_valid_r   <= 1'b0;
      out_feature_r <= '0;
    end else if (soft_rst) begin
      state_r       <= ST_IDLE;
      g_r           <= '0;
      s1_g_r        <= '0;
      s1_valid_r    <= 1'b0;
      feat_r        <= '0;
      relu_r        <= 1'b0;
      shift_r       <= 5'd0;
      out_valid_r   <= 1'b0;
      out_feature_r <= '0;
    end else begin
      s1_valid_r <= 1'b0;
      if (s1_valid_r) begin
        for (int p = 0; p < P; p++) begin
          out_feature_r[(int'(s1_g_r) * P + p) * O_F_BW +: O_F_BW] <= r_s[p];
        end
      end
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            feat_r  <= bus.feature_map;
            relu_r  <= cfg_relu;
            shift_r <= cfg_shift;
            g_r     <= '0;
            state_r <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (g_r < GW'(G)) begin
            s1_valid_r <= 1'b1;
            s1_g_r     <= g_r;
            g_r        <= g_r + GW'(1);
          end
          // Leave once the final pass has been written back.
          if (s1_valid_r && (s1_g_r == GW'(G - 1))) begin
            state_r     <= ST_OUT;
            out_valid_r <= 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_r == ST_IDLE);
  assign bus.out_valid   = out_valid_r;
  assign bus.out_feature = out_feature_r;
endmodule

// File: tb/tb_cnn_tiled_processor.sv
// Self-checking bench: directed vector table, randomized windows against an
// arithmetic reference model, backpressure and soft-reset sequences.
module tb_cnn_tiled_processor;
  localparam int N  = 9;
  localparam int CO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic soft_rst = 1'b0;
  logic cfg_relu = 1'b0;
  logic [4:0] cfg_shift = 5'd0;
  logic [CO*N*8-1:0] weights = '0;
  logic [CO*16-1:0] biases = '0;

  cnn_tiled_processor_if #(.N(N), .I_F_BW(8), .CO(CO), .O_F_BW(8)) bus ();

  cnn_tiled_processor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .soft_rst  (soft_rst),
    .cfg_relu  (cfg_relu),
    .cfg_shift (cfg_shift),
    .weights   (weights),
    .biases    (biases),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int m_f [N];
  int m_w [CO][N];
  int m_b [CO];
  int m_sh;
  int m_relu;

  typedef struct {
    int f; int w; int b; int sh; int relu; int exp;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: exact dot product + bias, floor((b + 2^(s-1)) / 2^s), ReLU, clamp.
  function automatic int model_ch(input int c);
    longint s, d, q;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(m_f[i]) * longint'(m_w[c][i]);
    s += m_b[c];
    if (m_sh > 0) begin
      d = longint'(1) << m_sh;
      s = s + d / 2;
      q = s / d;
      if ((s % d != 0) && (s < 0)) q = q - 1;
      s = q;
    end
    if ((m_relu != 0) && (s < 0)) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return int'(s);
  endfunction

  task automatic drive_model();
    for (int i = 0; i < N; i++) bus.feature_map[i*8 +: 8] = 8'(m_f[i]);
    for (int c = 0; c < CO; c++) begin
      for (int i = 0; i < N; i++) weights[(c*N + i)*8 +: 8] = 8'(m_w[c][i]);
      biases[c*16 +: 16] = 16'(m_b[c]);
    end
    cfg_shift = 5'(m_sh);
    cfg_relu = (m_relu != 0);
  endtask

  task automatic randomize_model();
    for (int i = 0; i < N; i++) m_f[i] = int'($urandom_range(255)) - 128;
    for (int c = 0; c < CO; c++) begin
      for (int i = 0; i < N; i++) m_w[c][i] = int'($urandom_range(255)) - 128;
      m_b[c] = int'($urandom_range(8000)) - 4000;
    end
    m_sh = int'($urandom_range(12));
    m_relu = int'($urandom_range(1));
  endtask

  task automatic send_window();
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", longint'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_model(input string tag);
    for (int c = 0; c < CO; c++)
      chk($sformatf("%s_ch%0d", tag, c), longint'($signed(bus.out_feature[c*8 +: 8])), model_ch(c));
  endtask

  task automatic take_out(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, longint'(bus.out_valid), 0);
    chk({tag, "_ready_back"}, longint'(bus.in_ready), 1);
  endtask

  initial begin
    int lat;
    int seen;
    logic [CO*8-1:0] snap;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.feature_map = '0;

    tbl[0] = '{f: 1,   w: 1,    b: 0,  sh: 0, relu: 0, exp: 9};
    tbl[1] = '{f: 127, w: 127,  b: 0,  sh: 0, relu: 0, exp: 127};
    tbl[2] = '{f: 127, w: -128, b: 0,  sh: 0, relu: 0, exp: -128};
    tbl[3] = '{f: 127, w: -128, b: 0,  sh: 0, relu: 1, exp: 0};
    tbl[4] = '{f: 1,   w: 1,    b: 0,  sh: 2, relu: 0, exp: 2};
    tbl[5] = '{f: 1,   w: -1,   b: 0,  sh: 2, relu: 0, exp: -2};
    tbl[6] = '{f: 1,   w: 1,    b: -1, sh: 0, relu: 0, exp: 8};

    // Reset behaviour during and after rst_n.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_feature", longint'(bus.out_feature), 0);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", longint'(bus.out_valid), 0);
    chk("post_rst_in_ready", longint'(bus.in_ready), 1);

    // Directed vector table.
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < N; i++) m_f[i] = tbl[k].f;
      for (int c = 0; c < CO; c++) begin
        for (int i = 0; i < N; i++) m_w[c][i] = tbl[k].w;
        m_b[c] = tbl[k].b;
      end
      m_sh = tbl[k].sh;
      m_relu = tbl[k].relu;
      drive_model();
      send_window();
      wait_out(lat);
      chk($sformatf("tbl%0d_latency", k), lat, 3);
      for (int c = 0; c < CO; c++)
        chk($sformatf("tbl%0d_ch%0d", k, c), longint'($signed(bus.out_feature[c*8 +: 8])), tbl[k].exp);
      take_out($sformatf("tbl%0d", k));
    end

    // Randomized windows against the reference model.
    for (int k = 0; k < 24; k++) begin
      randomize_model();
      drive_model();
      send_window();
      wait_out(lat);
      chk($sformatf("rnd%0d_latency", k), lat, 3);
      check_model($sformatf("rnd%0d", k));
      take_out($sformatf("rnd%0d", k));
    end

    // Backpressure: output held, new windows refused, then one handshake.
    randomize_model();
    drive_model();
    send_window();
    wait_out(lat);
    chk("bp_latency", lat, 3);
    snap = bus.out_feature;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.feature_map = {$urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", k), longint'(bus.out_valid), 1);
      chk($sformatf("bp%0d_stable", k), longint'(bus.out_feature), longint'(snap));
      chk($sformatf("bp%0d_in_ready", k), longint'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    check_model("bp_data");
    take_out("bp");
    randomize_model();
    drive_model();
    send_window();
    wait_out(lat);
    chk("bp2_latency", lat, 3);
    check_model("bp2");
    take_out("bp2");

    // Soft reset the cycle after acceptance discards the window.
    randomize_model();
    for (int c = 0; c < CO; c++) m_b[c] = 100;
    drive_model();
    send_window();
    soft_rst = 1'b1;
    @(posedge clk); #1;
    soft_rst = 1'b0;
    chk("srst_in_ready", longint'(bus.in_ready), 1);
    chk("srst_out_feature", longint'(bus.out_feature), 0);
    chk("srst_out_valid", longint'(bus.out_valid), 0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("srst_no_output", seen, 0);
    randomize_model();
    drive_model();
    send_window();
    wait_out(lat);
    chk("srst_next_latency", lat, 3);
    check_model("srst_next");
    take_out("srst_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
